// File: rtl/dac_pkg.sv
// Shared constants and FSM state type for the transmit DAC slice.
//   DAC_BITS   : resolution of the serial DAC code
//   FRAME_BITS : bits per sync_n frame (mode bits + code)
//   MODE_BITS  : leading zero mode bits sent before the code
package dac_pkg;
  localparam int DAC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int MODE_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/transmit_dac_if.sv
// Sample handshake between the equalizer and the DAC transmitter.
//   yk    : signed Q p.f sample
//   valid : yk is valid this cycle
//   ready : transmitter idle, sample taken on valid & ready
interface transmit_dac_if #(parameter int Width = 23) ();
  logic signed [Width-1:0] yk;
  logic                    valid;
  logic                    ready;

  modport master (output yk, valid, input ready);
  modport slave  (input yk, valid, output ready);
endinterface

// File: rtl/dac_code_conv.sv
// Combinational Q p.f -> 12-bit offset-binary DAC code.
//   yk   : signed sample, full scale +/-1.0 = +/-(1 << f)
//   code : offset-binary code (MSB of the signed value inverted)
// Optional macro DAC_SATURATE_EN clamps out-of-range samples instead of
// letting the bit slice wrap.
module dac_code_conv
  import dac_pkg::*;
#(
  parameter int f     = 14,
  parameter int Width = 23
) (
  input  logic signed [Width-1:0]    yk,
  output logic        [DAC_BITS-1:0] code
);
  logic [DAC_BITS-1:0] s;

`ifdef DAC_SATURATE_EN
  localparam logic signed [Width-1:0] POS_ONE = {{(Width-f-1){1'b0}}, 1'b1, {f{1'b0}}};
  localparam logic signed [Width-1:0] NEG_ONE = -POS_ONE;

  always_comb begin
    s = yk[f -: DAC_BITS];
    if (yk >= POS_ONE)     s = {1'b0, {(DAC_BITS-1){1'b1}}};
    else if (yk < NEG_ONE) s = {1'b1, {(DAC_BITS-1){1'b0}}};
  end
`else
  // Bits outside the slice are intentionally dropped (two's-complement wrap).
  logic unused_bits;
  assign unused_bits = ^{yk[Width-1:f+1], yk[f-DAC_BITS:0]};
  assign s = yk[f -: DAC_BITS];
`endif

  assign code = {~s[DAC_BITS-1], s[DAC_BITS-2:0]};
endmodule

// File: rtl/transmit_dac.sv
// Serial DAC transmitter: takes one equalizer sample, converts it to a
// 12-bit offset-binary code and shifts a 16-bit frame (4 zero mode bits +
// code, MSB first) out on sync_n/dac_sck/dout.
//   sclk, rst : system clock, async active-low reset
//   smp       : sample handshake (slave side)
//   sync_n    : frame select, low for the 16 frame bits
//   dac_sck   : serial clock, high then low within each bit (DAC samples on fall)
//   dout      : serial data
//   done      : one-cycle pulse in the last cycle of the frame
// Optional macro DAC_SATURATE_EN enables clamping in dac_code_conv.
module transmit_dac
  import dac_pkg::*;
#(
  parameter int p     = 8,
  parameter int f     = 14,
  parameter int Width = p + f + 1,
  parameter int DIV   = 2
) (
  input  logic                 sclk,
  input  logic                 rst,
  transmit_dac_if.slave        smp,
  output logic                 sync_n,
  output logic                 dac_sck,
  output logic                 dout,
  output logic                 done
);
  localparam int BITT = 2 * DIV;
  localparam int DW   = $clog2(BITT + 1);
  localparam int BW   = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DLAST = DW'(BITT - 1);
  localparam logic [DW-1:0] DHALF = DW'(DIV);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_BITS - 1);

  if (p + f + 1 != Width) begin : g_bad_width
    $error("transmit_dac: Width must equal p+f+1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("transmit_dac: DIV must be >= 1");
  end

  state_t                state, nstate;
  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] sh;
  logic [DAC_BITS-1:0]   code;
  logic                  bit_end, last_bit;

  dac_code_conv #(.f(f), .Width(Width)) u_conv (
    .yk   (smp.yk),
    .code (code)
  );

  assign bit_end  = (div_cnt == DLAST);
  assign last_bit = (bit_cnt == BLAST);

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (smp.valid)           nstate = SHIFT;
      SHIFT:   if (bit_end && last_bit) nstate = GAP;
      GAP:     if (bit_end)             nstate = IDLE;
      default:                          nstate = IDLE;
    endcase
  end

  // Divider counts 0..2*DIV-1 per bit in SHIFT and once through in GAP.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (smp.valid) sh <= {{MODE_BITS{1'b0}}, code};
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= {sh[FRAME_BITS-2:0], 1'b0};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP:     div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
        default: div_cnt <= '0;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset forces them at once.
  assign smp.ready = (state == IDLE);
  assign sync_n    = (state != SHIFT);
  assign dac_sck   = (state != SHIFT) || (div_cnt < DHALF);
  assign dout      = (state == SHIFT) && sh[FRAME_BITS-1];
  assign done      = (state == SHIFT) && bit_end && last_bit;
endmodule
